// File: rtl/trap_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trap_controller_pkg
//  Description : Shared constants for the machine-mode trap controller:
//                exception codes, privilege levels, CSR addresses, mstatus
//                bit positions and the FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package trap_controller_pkg;

    // XLEN width encoding; datapath width is 1 << (XLEN + 4)
    localparam int XLEN_32B = 1;
    localparam int XLEN_64B = 2;

    // Exception codes carried down the pipe (value equals the mcause number)
    localparam logic [3:0] E_INSTR_ADDR_MISALIGNED = 4'd0;
    localparam logic [3:0] E_ILLEGAL_INSTR         = 4'd2;
    localparam logic [3:0] E_LOAD_ADDR_MISALIGNED  = 4'd4;
    localparam logic [3:0] E_STORE_ACCESS_FAULT    = 4'd7;
    localparam logic [3:0] E_ECALL                 = 4'd8;
    localparam logic [3:0] NO_E                    = 4'hF;

    // Privilege levels
    localparam logic [1:0] PRIV_USER    = 2'b00;
    localparam logic [1:0] PRIV_MACHINE = 2'b11;

    // CSR addresses owned by this block
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // mstatus field positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LSB  = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRAP = 2'd1,
        ST_RET  = 2'd2
    } trap_state_t;

    // Load/store misaligned or access-fault causes report the effective address
    function automatic logic is_mem_fault(input logic [3:0] code);
        return (code >= E_LOAD_ADDR_MISALIGNED) && (code <= E_STORE_ACCESS_FAULT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/trap_controller_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : trap_tag_pipe
//  Description : Carries fetch-stage exception tags {code, pc, instr} through
//                Decode into Execute, honouring stall and flush (flush wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_tag_pipe
    import trap_controller_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [3:0]   i_code_f,
    input  logic [W-1:0] i_pc_f,
    input  logic [31:0]  i_instr_f,
    input  logic         i_stall_d,
    input  logic         i_flush_d,
    input  logic         i_stall_e,
    input  logic         i_flush_e,
    output logic [3:0]   o_code_e,
    output logic [W-1:0] o_pc_e,
    output logic [31:0]  o_instr_e
);

    logic [3:0]   r_code_d;
    logic [W-1:0] r_pc_d;
    logic [31:0]  r_instr_d;
    logic [3:0]   r_code_e;
    logic [W-1:0] r_pc_e;
    logic [31:0]  r_instr_e;

    // Decode tag: a flush only needs to kill the code, pc/instr are don't-care
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_code_d  <= NO_E;
            r_pc_d    <= '0;
            r_instr_d <= '0;
        end else if (i_flush_d) begin
            r_code_d  <= NO_E;
        end else if (!i_stall_d) begin
            r_code_d  <= i_code_f;
            r_pc_d    <= i_pc_f;
            r_instr_d <= i_instr_f;
        end
    end

    // Execute tag: follows Decode tag under the Execute stall/flush controls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_code_e  <= NO_E;
            r_pc_e    <= '0;
            r_instr_e <= '0;
        end else if (i_flush_e) begin
            r_code_e  <= NO_E;
        end else if (!i_stall_e) begin
            r_code_e  <= r_code_d;
            r_pc_e    <= r_pc_d;
            r_instr_e <= r_instr_d;
        end
    end

    assign o_code_e  = r_code_e;
    assign o_pc_e    = r_pc_e;
    assign o_instr_e = r_instr_e;

endmodule
`default_nettype wire

// File: rtl/trap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : trap_controller
//  Description : Machine-mode trap and mret engine. Arbitrates Execute and
//                fetch-tag exceptions, updates mepc/mcause/mtval/mstatus and
//                privilege, then pulses a pipeline flush and fetch redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter  int XLEN = XLEN_64B,
    localparam int W    = 1 << (XLEN + 4)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [3:0]   i_exception_code_f,
    input  logic [W-1:0] i_pc_f,
    input  logic [31:0]  i_instr_f,
    input  logic         i_stall_d,
    input  logic         i_flush_d,
    input  logic         i_stall_e,
    input  logic         i_flush_e,
    input  logic [3:0]   i_exception_code_e,
    input  logic [W-1:0] i_pc_e,
    input  logic [W-1:0] i_alu_out_e,
    input  logic         i_mret_e,
    input  logic [W-1:0] i_mtvec,
    input  logic         i_csr_we,
    input  logic [11:0]  i_csr_addr,
    input  logic [W-1:0] i_csr_wdata,
    output logic [1:0]   o_current_privilege,
    output logic [W-1:0] o_mepc,
    output logic [W-1:0] o_mcause,
    output logic [W-1:0] o_mtval,
    output logic [W-1:0] o_mstatus,
    output logic         o_trap_flush,
    output logic         o_pc_redirect_valid,
    output logic [W-1:0] o_pc_redirect,
    output logic         o_busy
);

    localparam logic [W-1:0] C_ALIGN_MASK = ~W'(3);

    trap_state_t  r_state;
    logic         r_trap_flush;
    logic         r_redirect_valid;
    logic [W-1:0] r_redirect;
    logic         r_busy;

    logic [1:0]   r_priv;
    logic [W-1:0] r_mepc;
    logic [W-1:0] r_mcause;
    logic [W-1:0] r_mtval;
    logic         r_mie;
    logic         r_mpie;
    logic [1:0]   r_mpp;

    logic [3:0]   w_tag_code;
    logic [W-1:0] w_tag_pc;
    logic [31:0]  w_tag_instr;

    // The trap flush also bubbles the tags so younger fetch faults die
    trap_tag_pipe #(.W(W)) u_tag_pipe (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_code_f  (i_exception_code_f),
        .i_pc_f    (i_pc_f),
        .i_instr_f (i_instr_f),
        .i_stall_d (i_stall_d),
        .i_flush_d (i_flush_d | r_trap_flush),
        .i_stall_e (i_stall_e),
        .i_flush_e (i_flush_e | r_trap_flush),
        .o_code_e  (w_tag_code),
        .o_pc_e    (w_tag_pc),
        .o_instr_e (w_tag_instr)
    );

    logic         w_e_valid;
    logic         w_from_e;
    logic [3:0]   w_eff_code;
    logic         w_has_cause;
    logic         w_mret_bad;
    logic         w_take_trap;
    logic         w_take_ret;
    logic [3:0]   w_trap_code;
    logic [W-1:0] w_trap_mcause;
    logic [W-1:0] w_trap_mepc;
    logic [W-1:0] w_trap_mtval;

    // Trap decision: Execute's own cause is older than the fetch tag and wins
    always_comb begin
        w_e_valid     = (r_state == ST_IDLE) && !i_stall_e;
        w_from_e      = (i_exception_code_e != NO_E);
        w_eff_code    = w_from_e ? i_exception_code_e : w_tag_code;
        w_has_cause   = (w_eff_code != NO_E);
        w_mret_bad    = i_mret_e && !w_has_cause && (r_priv != PRIV_MACHINE);
        w_take_trap   = w_e_valid && (w_has_cause || w_mret_bad);
        w_take_ret    = w_e_valid && i_mret_e && !w_has_cause && (r_priv == PRIV_MACHINE);
        w_trap_code   = w_has_cause ? w_eff_code : E_ILLEGAL_INSTR;
        w_trap_mcause = (w_trap_code == E_ECALL) ? W'(E_ECALL + {2'b00, r_priv})
                                                 : W'(w_trap_code);
        w_trap_mepc   = ((w_has_cause && !w_from_e) ? w_tag_pc : i_pc_e) & C_ALIGN_MASK;
        w_trap_mtval  = '0;
        if (w_has_cause) begin
            if (w_from_e) begin
                if (is_mem_fault(w_eff_code)) w_trap_mtval = i_alu_out_e;
            end else if (w_eff_code == E_INSTR_ADDR_MISALIGNED) begin
                w_trap_mtval = w_tag_pc;
            end else if (w_eff_code == E_ILLEGAL_INSTR) begin
                w_trap_mtval = W'(w_tag_instr);
            end
        end
    end

    // Control FSM with registered single-cycle flush/redirect pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= ST_IDLE;
            r_trap_flush     <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect       <= '0;
            r_busy           <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take_trap) begin
                        r_state          <= ST_TRAP;
                        r_trap_flush     <= 1'b1;
                        r_redirect_valid <= 1'b1;
                        r_redirect       <= i_mtvec & C_ALIGN_MASK;
                        r_busy           <= 1'b1;
                    end else if (w_take_ret) begin
                        r_state          <= ST_RET;
                        r_trap_flush     <= 1'b1;
                        r_redirect_valid <= 1'b1;
                        r_redirect       <= r_mepc;
                        r_busy           <= 1'b1;
                    end
                end
                default: begin
                    r_state          <= ST_IDLE;
                    r_trap_flush     <= 1'b0;
                    r_redirect_valid <= 1'b0;
                    r_redirect       <= '0;
                    r_busy           <= 1'b0;
                end
            endcase
        end
    end

    // Architectural CSRs: trap/mret capture takes priority over software writes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_priv   <= PRIV_MACHINE;
            r_mepc   <= '0;
            r_mcause <= '0;
            r_mtval  <= '0;
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_mpp    <= PRIV_USER;
        end else if (w_take_trap) begin
            r_mepc   <= w_trap_mepc;
            r_mcause <= w_trap_mcause;
            r_mtval  <= w_trap_mtval;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
            r_mpp    <= r_priv;
            r_priv   <= PRIV_MACHINE;
        end else if (w_take_ret) begin
            r_priv   <= r_mpp;
            r_mie    <= r_mpie;
            r_mpie   <= 1'b1;
            r_mpp    <= PRIV_USER;
        end else if ((r_state == ST_IDLE) && i_csr_we) begin
            case (i_csr_addr)
                CSR_MSTATUS: begin
                    r_mie  <= i_csr_wdata[MSTATUS_MIE_BIT];
                    r_mpie <= i_csr_wdata[MSTATUS_MPIE_BIT];
                    r_mpp  <= (i_csr_wdata[MSTATUS_MPP_LSB +: 2] == 2'b10)
                              ? PRIV_USER : i_csr_wdata[MSTATUS_MPP_LSB +: 2];
                end
                CSR_MEPC:   r_mepc   <= i_csr_wdata & C_ALIGN_MASK;
                CSR_MCAUSE: r_mcause <= i_csr_wdata;
                CSR_MTVAL:  r_mtval  <= i_csr_wdata;
                default: ;
            endcase
        end
    end

    // Assemble mstatus view from the implemented fields
    always_comb begin
        o_mstatus                             = '0;
        o_mstatus[MSTATUS_MIE_BIT]            = r_mie;
        o_mstatus[MSTATUS_MPIE_BIT]           = r_mpie;
        o_mstatus[MSTATUS_MPP_LSB +: 2]       = r_mpp;
    end

    assign o_current_privilege = r_priv;
    assign o_mepc              = r_mepc;
    assign o_mcause            = r_mcause;
    assign o_mtval             = r_mtval;
    assign o_trap_flush        = r_trap_flush;
    assign o_pc_redirect_valid = r_redirect_valid;
    assign o_pc_redirect       = r_redirect;
    assign o_busy              = r_busy;

endmodule
`default_nettype wire
